// File: rtl/calc_entry.sv
// Operand-entry front end for the 4-bit calculator.
// Debounces next/clear buttons and steps A, B, operator, show.
module calc_entry_db #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module calc_entry #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_clear,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] operator,
  output logic [1:0] stage,
  output logic       result_valid,
  output logic       err
);
  typedef enum logic [1:0] {
    A_IN  = 2'b00,
    B_IN  = 2'b01,
    OP_IN = 2'b10,
    SHOW  = 2'b11
  } state_t;

  state_t state;
  logic   nxt_p;
  logic   clr_p;

  calc_entry_db #(.N(DB_CYCLES)) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_next),
    .press (nxt_p)
  );

  calc_entry_db #(.N(DB_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clear),
    .press (clr_p)
  );

  assign stage = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= A_IN;
      a            <= '0;
      b            <= '0;
      operator     <= 2'b01;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr_p) begin
        state        <= A_IN;
        a            <= '0;
        b            <= '0;
        operator     <= 2'b01;
        result_valid <= 1'b0;
      end else if (nxt_p) begin
        unique case (state)
          A_IN: begin
            a     <= sw;
            state <= B_IN;
          end
          B_IN: begin
            b     <= sw;
            state <= OP_IN;
          end
          OP_IN: begin
            // divide by zero is refused; stay so the user can retry
            if (sw[1:0] == 2'b00 && b == 4'd0) begin
              err <= 1'b1;
            end else begin
              operator     <= sw[1:0];
              state        <= SHOW;
              result_valid <= 1'b1;
            end
          end
          SHOW: begin
            state        <= A_IN;
            result_valid <= 1'b0;
          end
          default: state <= A_IN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc_entry.sv
// Scoreboard bench for calc_entry with DB_CYCLES=4.
// Each press pushes its expected output and landing cycle.
module tb_calc_entry;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       btn_next = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] operator;
  logic [1:0] stage;
  logic       result_valid;
  logic       err;

  calc_entry #(.DB_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_next     (btn_next),
    .btn_clear    (btn_clear),
    .a            (a),
    .b            (b),
    .operator     (operator),
    .stage        (stage),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] v;
    int          c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [13:0] ov();
    return {a, b, operator, stage, result_valid, err};
  endfunction

  function automatic logic [13:0] mk(
    input logic [3:0] ea, input logic [3:0] eb,
    input logic [1:0] eo, input logic [1:0] es,
    input logic ev, input logic ee);
    return {ea, eb, eo, es, ev, ee};
  endfunction

  task automatic chk(input string n, input logic [13:0] act,
                     input logic [13:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  initial begin : monitor
    logic [13:0] prev;
    logic [13:0] cur;
    exp_t e;
    prev = ov();
    forever begin
      @(negedge clk);
      cur = ov();
      if (!rst_n) begin
        prev = cur;
      end else if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change actual=%h cyc=%0d required=none",
                   cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || cyc != e.c) begin
            failures++;
            $display("FAIL update actual=%h@%0d required=%h@%0d",
                     cur, cyc, e.v, e.c);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic step(input logic nx, input logic cl,
                      input logic [3:0] s, input int hold,
                      input int nexp, input logic [13:0] e1,
                      input logic [13:0] e2);
    exp_t e;
    @(negedge clk);
    sw = s;
    btn_next = nx;
    btn_clear = cl;
    if (nexp > 0) begin
      e.v = e1;
      e.c = cyc + 8;
      q.push_back(e);
    end
    if (nexp > 1) begin
      e.v = e2;
      e.c = cyc + 9;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  localparam logic [13:0] RST = {4'd0, 4'd0, 2'b01, 2'b00, 1'b0, 1'b0};

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("reset_values", ov(), RST);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    step(1, 0, 4'd9, 10, 1, mk(9, 0, 2'b01, 2'b01, 0, 0), '0);
    step(1, 0, 4'd3, 10, 1, mk(9, 3, 2'b01, 2'b10, 0, 0), '0);
    step(1, 0, 4'd2, 10, 1, mk(9, 3, 2'b10, 2'b11, 1, 0), '0);
    step(1, 0, 4'd0, 10, 1, mk(9, 3, 2'b10, 2'b00, 0, 0), '0);
    step(1, 0, 4'd7, 10, 1, mk(7, 3, 2'b10, 2'b01, 0, 0), '0);
    step(1, 0, 4'd0, 3, 0, '0, '0);
    step(1, 0, 4'd0, 20, 1, mk(7, 0, 2'b10, 2'b10, 0, 0), '0);
    step(1, 0, 4'd0, 10, 2, mk(7, 0, 2'b10, 2'b10, 0, 1),
         mk(7, 0, 2'b10, 2'b10, 0, 0));
    step(1, 0, 4'd1, 10, 1, mk(7, 0, 2'b01, 2'b11, 1, 0), '0);
    step(1, 0, 4'd0, 10, 1, mk(7, 0, 2'b01, 2'b00, 0, 0), '0);
    step(1, 0, 4'd5, 10, 1, mk(5, 0, 2'b01, 2'b01, 0, 0), '0);
    step(1, 0, 4'd4, 10, 1, mk(5, 4, 2'b01, 2'b10, 0, 0), '0);
    step(1, 1, 4'd3, 10, 1, RST, '0);
    step(1, 0, 4'd6, 10, 1, mk(6, 0, 2'b01, 2'b01, 0, 0), '0);
    step(1, 0, 4'd2, 10, 1, mk(6, 2, 2'b01, 2'b10, 0, 0), '0);
    step(1, 0, 4'd0, 10, 1, mk(6, 2, 2'b00, 2'b11, 1, 0), '0);
    step(1, 0, 4'd0, 10, 1, mk(6, 2, 2'b00, 2'b00, 0, 0), '0);
    step(1, 0, 4'd5, 10, 1, mk(5, 2, 2'b00, 2'b01, 0, 0), '0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_entry", ov(), RST);
    btn_next = 1'b1;
    sw = 4'd8;
    repeat (10) @(negedge clk);
    chk("reset_held_btn", ov(), RST);
    #2 rst_n = 1'b1;
    e.v = mk(8, 0, 2'b01, 2'b01, 0, 0);
    e.c = cyc + 8;
    q.push_back(e);
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (20) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_updates actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
